// File: rtl/jk_updown_counter.sv
`default_nettype none
// ============================================================================
// jk_updown_counter : modulo-N up/down counter built from JK flip-flop stages
// Rev 1.0
// ============================================================================

module jk_ff_stage (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);
    logic state_q;
    logic state_d;

    // Characteristic equation: Q+ = J~Q | ~KQ
    always_comb begin
        state_d = (j & ~state_q) | (~k & state_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;
endmodule

module jk_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);
    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("jk_updown_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] C_MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
    localparam logic [WIDTH:0]   C_MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] din_clamp;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] j_in;
    logic [WIDTH-1:0] k_in;
    logic             illegal;

    always_comb begin
        din_clamp = ({1'b0, din} >= C_MOD_EXT) ? C_MAX_VAL : din;
        illegal   = ({1'b0, q} >= C_MOD_EXT);
        cnt_next  = q;
        if (up) begin
            cnt_next = (illegal || (q == C_MAX_VAL)) ? '0 : (q + C_ONE);
        end else begin
            cnt_next = (illegal || (q == '0)) ? C_MAX_VAL : (q - C_ONE);
        end
        // Only bits that must flip get J=K=1
        toggle = q ^ cnt_next;
    end

    always_comb begin
        j_in = '0;
        k_in = '0;
        if (load) begin
            j_in = din_clamp;
            k_in = ~din_clamp;
        end else if (en) begin
            j_in = toggle;
            k_in = toggle;
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_stage
            jk_ff_stage u_stage (
                .clk (clk),
                .rst (rst),
                .j   (j_in[i]),
                .k   (k_in[i]),
                .q   (q[i])
            );
        end
    endgenerate

    assign qb = ~q;
    assign tc = en & ~load & rst & ((up & (q == C_MAX_VAL)) | (~up & (q == '0)));
endmodule
`default_nettype wire

// File: tb/tb_jk_updown_counter.sv
`default_nettype none
// Directed self-checking bench for jk_updown_counter (mod-10 instance plus
// a cascaded pair of mod-16 instances).

module tb_jk_updown_counter;
    logic       clk = 1'b0;
    logic       rst;
    logic       en, up, load;
    logic [3:0] din;
    logic [3:0] q, qb;
    logic       tc;

    logic       c_en, c_up, c_load;
    logic [3:0] c_din;
    logic [3:0] q_lo, qb_lo, q_hi, qb_hi;
    logic       tc_lo, tc_hi;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .din(din), .q(q), .qb(qb), .tc(tc)
    );

    jk_updown_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
        .clk(clk), .rst(rst), .en(c_en), .up(c_up), .load(c_load),
        .din(c_din), .q(q_lo), .qb(qb_lo), .tc(tc_lo)
    );

    jk_updown_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
        .clk(clk), .rst(rst), .en(tc_lo), .up(c_up), .load(c_load),
        .din(c_din), .q(q_hi), .qb(qb_hi), .tc(tc_hi)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_q(input string name, input logic [3:0] exp_q);
        n_checks++;
        if (q !== exp_q || qb !== ~exp_q)
            $display("FAIL %s: q=%h qb=%h expected q=%h qb=%h", name, q, qb, exp_q, ~exp_q);
        else
            n_pass++;
    endtask

    task automatic chk_tc(input string name, input logic exp_tc);
        n_checks++;
        if (tc !== exp_tc)
            $display("FAIL %s: tc=%b expected %b", name, tc, exp_tc);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        chk_q("reset_q", 4'h0);
        chk_tc("reset_tc", 1'b0);
    endtask

    task automatic test_up_wrap();
        int errs = 0;
        en = 1'b1; up = 1'b1; load = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            logic [3:0] cur;
            logic [3:0] exp_q;
            cur   = 4'((i - 1) % 10);
            exp_q = 4'(i % 10);
            if (tc !== (cur == 4'd9)) begin
                errs++;
                $display("FAIL up_wrap_tc: q=%h tc=%b expected %b", q, tc, (cur == 4'd9));
            end
            tick();
            if (q !== exp_q || qb !== ~exp_q) begin
                errs++;
                $display("FAIL up_wrap_q: step %0d q=%h expected %h", i, q, exp_q);
            end
        end
        n_checks++;
        if (errs == 0) n_pass++;
        chk_q("up_wrap_end", 4'h0);
    endtask

    task automatic test_down_wrap();
        en = 1'b1; up = 1'b0; load = 1'b0;
        #1;
        chk_tc("down_tc_at_0", 1'b1);
        tick();
        chk_q("down_wrap_9", 4'h9);
        chk_tc("down_tc_at_9", 1'b0);
        tick();
        chk_q("down_8", 4'h8);
    endtask

    task automatic test_load();
        load = 1'b1; en = 1'b1; up = 1'b1; din = 4'd6;
        #1;
        chk_tc("load_tc", 1'b0);
        tick();
        chk_q("load_6", 4'h6);
        din = 4'd13;
        tick();
        chk_q("load_clamp_13", 4'h9);
        din = 4'd15;
        tick();
        chk_q("load_clamp_15", 4'h9);
        en = 1'b0; din = 4'd3;
        tick();
        chk_q("load_en0", 4'h3);
        load = 1'b0;
    endtask

    task automatic test_hold();
        load = 1'b1; din = 4'd4;
        tick();
        load = 1'b0; en = 1'b0; up = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk_q("hold_q", 4'h4);
        chk_tc("hold_tc", 1'b0);
    endtask

    task automatic test_direction();
        en = 1'b1;
        up = 1'b1; tick(); chk_q("dir_5a", 4'h5);
        up = 1'b0; tick(); chk_q("dir_4a", 4'h4);
        up = 1'b1; tick(); chk_q("dir_5b", 4'h5);
        up = 1'b0; tick(); chk_q("dir_4b", 4'h4);
    endtask

    task automatic test_async_reset();
        load = 1'b1; din = 4'd0; en = 1'b1; up = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk_q("pre_reset_7", 4'h7);
        up = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk_q("async_reset_q", 4'h0);
        chk_tc("async_reset_tc", 1'b0);
        tick();
        chk_q("reset_held_q", 4'h0);
        #2 rst = 1'b1;
        en = 1'b0;
        #1;
        chk_tc("after_reset_tc", 1'b0);
    endtask

    task automatic test_full_range();
        int errs = 0;
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        c_en = 1'b1; c_up = 1'b0; c_load = 1'b0;
        #1;
        n_checks++;
        if (tc_lo !== 1'b1) $display("FAIL fr_tc_down0: tc=%b expected 1", tc_lo);
        else n_pass++;
        tick();
        n_checks++;
        if ({q_hi, q_lo} !== 8'hFF) $display("FAIL fr_down_wrap: q=%h expected ff", {q_hi, q_lo});
        else n_pass++;
        c_up = 1'b1;
        #1;
        n_checks++;
        if (tc_lo !== 1'b1 || tc_hi !== 1'b1)
            $display("FAIL fr_tc_up15: tc_lo=%b tc_hi=%b expected 1 1", tc_lo, tc_hi);
        else n_pass++;
        tick();
        n_checks++;
        if ({q_hi, q_lo} !== 8'h00) $display("FAIL fr_up_wrap: q=%h expected 00", {q_hi, q_lo});
        else n_pass++;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if ({q_hi, q_lo} !== 8'(i % 256) && errs < 4) begin
                $display("FAIL fr_cascade: step %0d q=%h expected %h", i, {q_hi, q_lo}, 8'(i % 256));
            end
            if ({q_hi, q_lo} !== 8'(i % 256)) errs++;
        end
        n_checks++;
        if (errs == 0) n_pass++;
        c_load = 1'b1; c_din = 4'd15;
        tick();
        c_load = 1'b0; c_en = 1'b0;
        n_checks++;
        if (q_lo !== 4'hF || qb_lo !== 4'h0) $display("FAIL fr_load15: q=%h qb=%h expected f 0", q_lo, qb_lo);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0;
        c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; c_din = 4'd0;
        #2;
        test_reset();
        #1 rst = 1'b1;
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_hold();
        test_direction();
        test_async_reset();
        test_full_range();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
